// File: rtl/ana_scan_ctrl_pkg.sv
// Shared definitions for the analog front-end scan controller.
// Readback is enabled by defining ANA_SCAN_READBACK_EN.
package ana_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PH1   = 3'd1,
        ST_GAP1  = 3'd2,
        ST_PH2   = 3'd3,
        ST_GAP2  = 3'd4,
        ST_LATCH = 3'd5,
        ST_DONE  = 3'd6
    } scan_state_t;

    // CPU I/O control register bit that raises START
    localparam int IOCTL_SCAN_START_BIT = 3;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CLK_DIV    = 2;

endpackage

// File: rtl/ana_sclk_gen.sv
// Two-phase non-overlapping scan clock sequencer: PH1, GAP1, PH2, GAP2 per bit.
// Optional feature macro: ANA_SCAN_READBACK_EN (handled by the parent).
module ana_sclk_gen
    import ana_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic last,
    output logic sclk1,
    output logic sclk2,
    output logic si_smp,
    output logic bit_done
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] PH_LAST = CW'(CLK_DIV - 1);

    scan_state_t    ph;
    logic [CW-1:0]  cnt;

    // Strobes mark the final cycle of PH2 / the GAP2 cycle, so the parent acts on the exiting edge
    assign si_smp   = (ph == ST_PH2) && (cnt == PH_LAST);
    assign bit_done = (ph == ST_GAP2);

    always_ff @(posedge clk) begin
        if (rst) begin
            ph    <= ST_IDLE;
            cnt   <= '0;
            sclk1 <= 1'b0;
            sclk2 <= 1'b0;
        end else begin
            case (ph)
                ST_IDLE: if (go) begin
                    ph    <= ST_PH1;
                    cnt   <= '0;
                    sclk1 <= 1'b1;
                end
                ST_PH1: if (cnt == PH_LAST) begin
                    ph    <= ST_GAP1;
                    cnt   <= '0;
                    sclk1 <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ST_GAP1: begin
                    ph    <= ST_PH2;
                    sclk2 <= 1'b1;
                end
                ST_PH2: if (cnt == PH_LAST) begin
                    ph    <= ST_GAP2;
                    cnt   <= '0;
                    sclk2 <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ST_GAP2: if (last) begin
                    ph <= ST_IDLE;
                end else begin
                    ph    <= ST_PH1;
                    sclk1 <= 1'b1;
                end
                default: ph <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ana_scan_ctrl.sv
// Serial scan controller: shifts PI out MSB-first on SO, pulses LAT, returns readback on PO.
// Readback (SI sampling, PO update) is built only when ANA_SCAN_READBACK_EN is defined.
module ana_scan_ctrl
    import ana_scan_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] PI,
    input  logic                  SI,
    output logic                  SO,
    output logic                  SCLK1,
    output logic                  SCLK2,
    output logic                  LAT,
    output logic                  BUSY,
    output logic                  RDY,
    output logic [DATA_WIDTH-1:0] PO
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAT_LAST = CW'(CLK_DIV - 1);

    // ST_PH1 here covers the whole bit loop; ana_sclk_gen owns the PH1..GAP2 detail
    scan_state_t            state;
    logic [DATA_WIDTH-1:0]  sreg;
    logic [BW-1:0]          bcnt;
    logic [CW-1:0]          lcnt;
    logic                   go, last, si_smp, bit_done, shin;

    assign go   = (state == ST_IDLE) && START;
    assign last = (bcnt == BW'(DATA_WIDTH - 1));

    ana_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk      (CLK),
        .rst      (RST),
        .go       (go),
        .last     (last),
        .sclk1    (SCLK1),
        .sclk2    (SCLK2),
        .si_smp   (si_smp),
        .bit_done (bit_done)
    );

`ifdef ANA_SCAN_READBACK_EN
    logic                  si_q;
    logic [DATA_WIDTH-1:0] po_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            si_q <= 1'b0;
            po_q <= '0;
        end else begin
            if (si_smp)
                si_q <= SI;
            if (state == ST_LATCH && lcnt == LAT_LAST)
                po_q <= sreg;
        end
    end

    assign shin = si_q;
    assign PO   = po_q;
`else
    logic unused_readback;
    assign unused_readback = SI ^ si_smp;
    assign shin = 1'b0;
    assign PO   = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            sreg  <= '0;
            bcnt  <= '0;
            lcnt  <= '0;
            SO    <= 1'b0;
            LAT   <= 1'b0;
            BUSY  <= 1'b0;
            RDY   <= 1'b0;
        end else begin
            RDY <= 1'b0;
            case (state)
                ST_IDLE: if (START) begin
                    state <= ST_PH1;
                    sreg  <= PI;
                    bcnt  <= '0;
                    SO    <= PI[DATA_WIDTH-1];
                    BUSY  <= 1'b1;
                end
                ST_PH1: if (bit_done) begin
                    sreg <= {sreg[DATA_WIDTH-2:0], shin};
                    SO   <= sreg[DATA_WIDTH-2];
                    bcnt <= bcnt + 1'b1;
                    if (last) begin
                        state <= ST_LATCH;
                        LAT   <= 1'b1;
                        lcnt  <= '0;
                    end
                end
                ST_LATCH: if (lcnt == LAT_LAST) begin
                    state <= ST_DONE;
                    LAT   <= 1'b0;
                    RDY   <= 1'b1;
                end else begin
                    lcnt <= lcnt + 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    SO    <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
